y86_stage_sequencer: RTL and testbench

Multi-cycle control FSM for the Y86 core. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update. It waits on instruction and data memory handshakes, skips the memory stage for instructions that do not access memory, and stops on halt or fault. It sits above the stage datapaths and drives their enables. `PC_EN` gates the PC update register so that `NEW_PC` advances exactly once per retired instruction.

---
 rtl/y86_stage_sequencer_pkg.sv | 82 ++++++++
 rtl/y86_stage_sequencer.sv | 132 +++++++++++++
 tb/tb_y86_stage_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_stage_sequencer_pkg.sv
// Purpose: shared constants, encodings and decode helpers for the Y86 stage sequencer.
// Contents: icode constants, stat codes, FSM state encoding, stage-enable bit positions,
//           needs_mem()/needs_wb() class decoders and the Moore enable decode per state.
package y86_stage_sequencer_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Highest legal icode; anything above is an invalid instruction
    localparam logic [3:0] I_MAX_VALID = I_POPQ;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_PCUPD     = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    // Bit positions inside the one-hot stage enable vector
    localparam int EN_FETCH = 0;
    localparam int EN_DEC   = 1;
    localparam int EN_EXEC  = 2;
    localparam int EN_MEM   = 3;
    localparam int EN_WB    = 4;
    localparam int EN_PC    = 5;
    localparam int EN_W     = 6;

    // Instructions that touch data memory
    function automatic logic needs_mem(input logic [3:0] ic);
        case (ic)
            I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    // Instructions that write the register file
    function automatic logic needs_wb(input logic [3:0] ic);
        case (ic)
            I_RRMOVQ, I_IRMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Moore output decode: exactly one enable per active state, none in HALT
    function automatic logic [EN_W-1:0] stage_enables(input state_t s);
        logic [EN_W-1:0] en;
        en = '0;
        case (s)
            S_FETCH:     en[EN_FETCH] = 1'b1;
            S_DECODE:    en[EN_DEC]   = 1'b1;
            S_EXECUTE:   en[EN_EXEC]  = 1'b1;
            S_MEMORY:    en[EN_MEM]   = 1'b1;
            S_WRITEBACK: en[EN_WB]    = 1'b1;
            S_PCUPD:     en[EN_PC]    = 1'b1;
            default:     en           = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/y86_stage_sequencer.sv
// Purpose: multi-cycle control FSM stepping one Y86 instruction through F/D/E/M/W/PC.
// Latency: 4 (nop/jXX), 5 (rrmovq/irmovq/OPq/rmmovq), 6 (mrmovq/call/ret/push/pop) cycles + waits.
// Backpressure: stalls in FETCH until imem_ready and in MEMORY (dmem_req held) until dmem_ready.
// Ports: CLK/RST_N (sync active-low); icode + imem_ready/imem_err from fetch;
//        dmem_ready/dmem_err from data memory; stage enables, dmem_req, PC_EN pulse;
//        stat (AOK/HLT/ADR/INS); cycle_cnt and instr_cnt wrap-around counters.
module y86_stage_sequencer
    import y86_stage_sequencer_pkg::*;
#(
    parameter int CNT_WID = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [3:0]         icode,
    input  logic               imem_ready,
    input  logic               imem_err,
    input  logic               dmem_ready,
    input  logic               dmem_err,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               exec_en,
    output logic               wb_en,
    output logic               dmem_req,
    output logic               PC_EN,
    output logic [2:0]         stat,
    output logic [CNT_WID-1:0] cycle_cnt,
    output logic [CNT_WID-1:0] instr_cnt
);

    state_t            state_q, state_d;
    stat_t             stat_q, stat_d;
    logic [3:0]        cur_icode_q, cur_icode_d;
    logic [EN_W-1:0]   en_q, en_d;
    logic [CNT_WID-1:0] cycle_cnt_q, instr_cnt_q;

    // Next-state and status logic
    always_comb begin
        state_d     = state_q;
        stat_d      = stat_q;
        cur_icode_d = cur_icode_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    if (imem_err) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else if (icode > I_MAX_VALID) begin
                        stat_d  = STAT_INS;
                        state_d = S_HALT;
                    end else if (icode == I_HALT) begin
                        stat_d  = STAT_HLT;
                        state_d = S_HALT;
                    end else begin
                        cur_icode_d = icode;
                        state_d     = S_DECODE;
                    end
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                // Memory classes first; of the rest, only nop/jXX skip writeback
                if (needs_mem(cur_icode_q)) begin
                    state_d = S_MEMORY;
                end else if (needs_wb(cur_icode_q)) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_PCUPD;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    if (dmem_err) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else if (needs_wb(cur_icode_q)) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        // rmmovq is the only memory class without writeback
                        state_d = S_PCUPD;
                    end
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD:     state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
        // Enables are registered from the next state so they line up with state_q
        en_d = stage_enables(state_d);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_FETCH;
            stat_q      <= STAT_AOK;
            cur_icode_q <= I_NOP;
            en_q        <= stage_enables(S_FETCH);
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            cur_icode_q <= cur_icode_d;
            en_q        <= en_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_WID'(1);
            end
            if (state_q == S_PCUPD) begin
                instr_cnt_q <= instr_cnt_q + CNT_WID'(1);
            end
        end
    end

    // Reset is held combinationally on the enables so nothing fires while RST_N is low,
    // including a request already in flight to data memory.
    assign fetch_en  = en_q[EN_FETCH] & RST_N;
    assign decode_en = en_q[EN_DEC]   & RST_N;
    assign exec_en   = en_q[EN_EXEC]  & RST_N;
    assign dmem_req  = en_q[EN_MEM]   & RST_N;
    assign wb_en     = en_q[EN_WB]    & RST_N;
    assign PC_EN     = en_q[EN_PC]    & RST_N;
    assign stat      = stat_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
module tb_y86_stage_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] icode;
    logic       imem_ready, imem_err, dmem_ready, dmem_err;
    logic       fetch_en, decode_en, exec_en, wb_en, dmem_req, PC_EN;
    logic [2:0] stat;
    logic [3:0] cycle_cnt, instr_cnt;

    int checks   = 0;
    int failures = 0;

    y86_stage_sequencer #(.CNT_WID(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .icode      (icode),
        .imem_ready (imem_ready),
        .imem_err   (imem_err),
        .dmem_ready (dmem_ready),
        .dmem_err   (dmem_err),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .exec_en    (exec_en),
        .wb_en      (wb_en),
        .dmem_req   (dmem_req),
        .PC_EN      (PC_EN),
        .stat       (stat),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; imem_ready = 1'b0; imem_err = 1'b0;
        dmem_ready = 1'b0; dmem_err = 1'b0; icode = 4'h1;
        step();
        step();
        RST_N = 1'b1;
    endtask

    // Runs one instruction from its FETCH cycle. Returns latency (FETCH..PCUPD inclusive,
    // -1 if it halted or ran out of budget). Outside the matching state the error and
    // ready inputs are driven hostile and icode is garbage, which must all be ignored.
    task automatic run_one(input logic [3:0] ic, input int iwait, input int dwait,
                           input logic ierr, input logic derr,
                           output int lat, output logic halted,
                           output logic saw_mem, output logic saw_wb);
        int  ip, dp, viol, n;
        logic done;
        ip = iwait; dp = dwait; viol = 0;
        lat = -1; halted = 1'b0; saw_mem = 1'b0; saw_wb = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            n = int'(fetch_en) + int'(decode_en) + int'(exec_en)
              + int'(dmem_req) + int'(wb_en) + int'(PC_EN);
            if (n == 0) begin
                halted = 1'b1;
                break;
            end
            if (n != 1) viol++;
            if (dmem_req) saw_mem = 1'b1;
            if (wb_en)    saw_wb  = 1'b1;
            icode = fetch_en ? ic : 4'hC;
            if (fetch_en && ip > 0) begin
                imem_ready = 1'b0; imem_err = 1'b1; ip--;
            end else if (fetch_en) begin
                imem_ready = 1'b1; imem_err = ierr;
            end else begin
                imem_ready = 1'b1; imem_err = 1'b1;
            end
            if (dmem_req && dp > 0) begin
                dmem_ready = 1'b0; dmem_err = 1'b1; dp--;
            end else if (dmem_req) begin
                dmem_ready = 1'b1; dmem_err = derr;
            end else begin
                dmem_ready = 1'b1; dmem_err = 1'b1;
            end
            done = PC_EN;
            if (PC_EN) lat = c + 1;
            step();
            if (done) break;
        end
        chk("onehot_enables", viol, 0);
    endtask

    int         lat, start;
    logic       halted, saw_mem, saw_wb;
    int         exp_pc [5] = '{3, 7, 12, 18, 24};
    logic [3:0] seq    [5] = '{4'h1, 4'h7, 4'h4, 4'h5, 4'h8};

    initial begin
        // ---- Reset state, then rrmovq with zero wait
        RST_N = 1'b0; imem_ready = 1'b0; imem_err = 1'b0;
        dmem_ready = 1'b0; dmem_err = 1'b0; icode = 4'h2;
        step();
        step();
        #1;
        chk("rst_fetch_en_forced", fetch_en, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_pc_en", PC_EN, 0);
        chk("rst_stat", stat, 1);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instr_cnt", instr_cnt, 0);
        RST_N = 1'b1;
        #1;
        chk("cycle0_fetch_en", fetch_en, 1);
        run_one(4'h2, 0, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        chk("rrmovq_latency", lat, 5);
        chk("rrmovq_wb", saw_wb, 1);
        #1;
        chk("rrmovq_instr_cnt", instr_cnt, 1);
        chk("rrmovq_cycle_cnt", cycle_cnt, 5);

        // ---- Back-to-back sequence 1,7,4,5,8
        do_reset();
        start = 0;
        for (int k = 0; k < 5; k++) begin
            run_one(seq[k], 0, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
            chk($sformatf("seq%0d_pc_en_cycle", k), start + lat - 1, exp_pc[k]);
            if (k < 2) chk($sformatf("seq%0d_no_dmem_req", k), saw_mem, 0);
            start = start + lat;
        end
        #1;
        chk("seq_instr_cnt", instr_cnt, 5);
        chk("seq_cycle_cnt", cycle_cnt, 25 % 16);

        // ---- Wait states
        do_reset();
        run_one(4'h3, 3, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        chk("irmovq_imem_wait_latency", lat, 8);
        run_one(4'hB, 0, 2, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        chk("popq_dmem_wait_latency", lat, 8);
        chk("popq_wb", saw_wb, 1);

        // ---- Invalid instruction
        do_reset();
        run_one(4'hC, 0, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        chk("ins_halted", halted, 1);
        chk("ins_no_pc_en", lat, -1);
        chk("ins_stat", stat, 4);
        chk("ins_cycle_cnt", cycle_cnt, 1);
        step(); step(); step();
        #1;
        chk("halt_cycle_frozen", cycle_cnt, 1);
        chk("halt_instr_frozen", instr_cnt, 0);
        chk("halt_stat_held", stat, 4);
        chk("halt_fetch_en", fetch_en, 0);

        // ---- Halt instruction
        do_reset();
        run_one(4'h0, 0, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        chk("hlt_halted", halted, 1);
        chk("hlt_stat", stat, 2);

        // ---- Data address fault on mrmovq
        do_reset();
        run_one(4'h5, 0, 1, 1'b0, 1'b1, lat, halted, saw_mem, saw_wb);
        chk("dadr_halted", halted, 1);
        chk("dadr_stat", stat, 3);
        chk("dadr_no_wb", saw_wb, 0);
        chk("dadr_no_pc_en", lat, -1);
        chk("dadr_cycle_cnt", cycle_cnt, 5);
        chk("dadr_instr_cnt", instr_cnt, 0);

        // ---- Fetch address fault after one wait cycle
        do_reset();
        run_one(4'h2, 1, 0, 1'b1, 1'b0, lat, halted, saw_mem, saw_wb);
        chk("iadr_stat", stat, 3);
        chk("iadr_cycle_cnt", cycle_cnt, 2);

        // ---- Reset during a MEMORY wait
        do_reset();
        run_one(4'h1, 0, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        chk("pre_mid_nop_latency", lat, 4);
        icode = 4'h5; imem_ready = 1'b1; imem_err = 1'b0;
        dmem_ready = 1'b0; dmem_err = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (dmem_req) break;
            step();
        end
        chk("mid_dmem_req_reached", dmem_req, 1);
        step();
        #1;
        chk("mid_dmem_req_held", dmem_req, 1);
        chk("mid_instr_cnt_before", instr_cnt, 1);
        RST_N = 1'b0;
        #1;
        chk("mid_req_dropped", dmem_req, 0);
        step();
        #1;
        chk("mid_cycle_cnt", cycle_cnt, 0);
        chk("mid_instr_cnt", instr_cnt, 0);
        chk("mid_stat", stat, 1);
        chk("mid_dmem_req_after", dmem_req, 0);
        RST_N = 1'b1;
        #1;
        chk("mid_state_fetch", fetch_en, 1);

        // ---- Counter wrap with 4-bit counters
        do_reset();
        for (int k = 0; k < 15; k++) begin
            run_one(4'h1, 0, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        end
        #1;
        chk("wrap_instr_15", instr_cnt, 15);
        run_one(4'h1, 0, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        #1;
        chk("wrap_instr_0", instr_cnt, 0);
        run_one(4'h1, 0, 0, 1'b0, 1'b0, lat, halted, saw_mem, saw_wb);
        #1;
        chk("wrap_instr_1", instr_cnt, 1);
        chk("wrap_cycle_cnt", cycle_cnt, 68 % 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
